// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: synchronizes the raw PS/2 lines, assembles
// 11-bit frames, and decodes make / break / E0-extended scancodes into a
// held-key view plus a wrapping keypress counter.
//
// state   | meaning
// IDLE    | no prefix pending
// EXT     | E0 received, next byte is an extended make or F0
// BRK     | F0 received, next byte names the released key
// EXT_BRK | E0 F0 received, next byte names the released extended key
module ps2_kbd_ctrl #(
  parameter int TIMEOUT = 50000,
  parameter int TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_valid,
  output logic [7:0] press_cnt,
  output logic       frame_err
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  logic [2:0]      clk_sync;
  logic [2:0]      data_sync;
  logic            fall;
  logic            data_bit;
  logic [3:0]      bit_cnt;
  logic [9:0]      shift;
  logic [TO_W-1:0] to_cnt;
  logic [10:0]     frame;
  logic            frame_ok;
  logic            byte_strobe;
  logic [7:0]      byte_data;
  state_t          state;

  // Falling edge is seen on the two oldest clock flops; data taken from the
  // oldest data flop, which is long settled while ps2_clk is high.
  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign data_bit = data_sync[2];

  // Completed frame as it will look once the current bit is included.
  assign frame    = {data_bit, shift};
  assign frame_ok = (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);

  // Three-flop synchronizers; idle-high lines so reset value is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
    end
  end

  // Frame receiver with inter-bit timeout; emits a byte strobe or an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= 4'd0;
      shift       <= 10'd0;
      to_cnt      <= '0;
      byte_strobe <= 1'b0;
      byte_data   <= 8'd0;
      frame_err   <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            byte_strobe <= 1'b1;
            byte_data   <= frame[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shift   <= {data_bit, shift[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TO_LIM) begin
          bit_cnt <= 4'd0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Scancode decoder: tracks prefixes and maintains the held-key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_code  <= 8'd0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      press_cnt <= 8'd0;
    end else if (byte_strobe) begin
      case (state)
        IDLE: begin
          if (byte_data == CODE_EXT) begin
            state <= EXT;
          end else if (byte_data == CODE_BRK) begin
            state <= BRK;
          end else if (!(key_valid && key_code == byte_data && !key_ext)) begin
            key_code  <= byte_data;
            key_ext   <= 1'b0;
            key_valid <= 1'b1;
            press_cnt <= press_cnt + 8'd1;
          end
        end
        EXT: begin
          if (byte_data == CODE_BRK) begin
            state <= EXT_BRK;
          end else if (byte_data == CODE_EXT) begin
            state <= EXT;
          end else begin
            state <= IDLE;
            if (!(key_valid && key_code == byte_data && key_ext)) begin
              key_code  <= byte_data;
              key_ext   <= 1'b1;
              key_valid <= 1'b1;
              press_cnt <= press_cnt + 8'd1;
            end
          end
        end
        BRK: begin
          state <= IDLE;
          if (key_valid && key_code == byte_data && !key_ext) begin
            key_valid <= 1'b0;
          end
        end
        EXT_BRK: begin
          state <= IDLE;
          if (key_valid && key_code == byte_data && key_ext) begin
            key_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
